// File: rtl/keypad_entry.sv
// Keypad front end: debounces raw strobes and accumulates a 4-digit decimal password.
// Optional `ENTRY_TIMEOUT_EN discards a partial entry after TIMEOUT_CYCLES idle cycles.

// State table (keypad_debounce)
//   state        | meaning
//   RELEASED     | no key down, waiting for key_valid
//   PRESS_WAIT   | key seen, counting stable cycles with an unchanged code
//   PRESSED      | press accepted (one event emitted), waiting for release
//   RELEASE_WAIT | key up, counting stable release cycles
module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_event,
    output logic [3:0] event_code
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    localparam logic [7:0] DB_TC = 8'(DEBOUNCE_CYCLES);

    db_state_t  state;
    logic [7:0] count;
    logic [3:0] latched_code;
    logic [7:0] count_inc;

    assign count_inc = count + 8'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RELEASED;
            count        <= 8'd0;
            latched_code <= 4'd0;
            key_event    <= 1'b0;
            event_code   <= 4'd0;
        end else begin
            key_event <= 1'b0;
            case (state)
                RELEASED: begin
                    if (key_valid) begin
                        latched_code <= key_code;
                        // A one-cycle debounce accepts the press on the very first edge.
                        if (DB_TC <= 8'd1) begin
                            state      <= PRESSED;
                            count      <= 8'd0;
                            key_event  <= 1'b1;
                            event_code <= key_code;
                        end else begin
                            state <= PRESS_WAIT;
                            count <= 8'd1;
                        end
                    end
                end

                PRESS_WAIT: begin
                    if (!key_valid) begin
                        state <= RELEASED;
                        count <= 8'd0;
                    end else if (key_code != latched_code) begin
                        latched_code <= key_code;
                        count        <= 8'd1;
                    end else if (count_inc >= DB_TC) begin
                        state      <= PRESSED;
                        count      <= 8'd0;
                        key_event  <= 1'b1;
                        event_code <= latched_code;
                    end else begin
                        count <= count_inc;
                    end
                end

                PRESSED: begin
                    if (!key_valid) begin
                        if (DB_TC <= 8'd1) begin
                            state <= RELEASED;
                            count <= 8'd0;
                        end else begin
                            state <= RELEASE_WAIT;
                            count <= 8'd1;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    // A bounce back to key-down resumes the held press without a new event.
                    if (key_valid) begin
                        state <= PRESSED;
                        count <= 8'd0;
                    end else if (count_inc >= DB_TC) begin
                        state <= RELEASED;
                        count <= 8'd0;
                    end else begin
                        count <= count_inc;
                    end
                end

                default: begin
                    state <= RELEASED;
                    count <= 8'd0;
                end
            endcase
        end
    end

endmodule

module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [13:0] password,
    output logic        touch,
    output logic [2:0]  digit_cnt,
    output logic        entry_error
);

    localparam logic [3:0] CODE_CLEAR = 4'd10;
    localparam logic [3:0] CODE_ENTER = 4'd11;
    localparam logic [2:0] MAX_DIGITS = 3'd4;

    logic        key_event;
    logic [3:0]  event_code;
    logic [13:0] shadow;
    logic [16:0] shadow_wide;
    logic [16:0] shadow_next;

    keypad_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_event  (key_event),
        .event_code (event_code)
    );

    // shadow*10 + digit; the 4-digit cap keeps the result below 10000, so [13:0] is exact.
    assign shadow_wide = {3'b000, shadow};
    assign shadow_next = (shadow_wide << 3) + (shadow_wide << 1) + {13'd0, event_code};

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYCLES);

    logic [15:0] idle_cnt;
    logic [15:0] idle_inc;

    assign idle_inc = idle_cnt + 16'd1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            password    <= 14'd0;
            touch       <= 1'b0;
            digit_cnt   <= 3'd0;
            entry_error <= 1'b0;
            shadow      <= 14'd0;
`ifdef ENTRY_TIMEOUT_EN
            idle_cnt    <= 16'd0;
`endif
        end else begin
            touch       <= 1'b0;
            entry_error <= 1'b0;
            if (key_event) begin
`ifdef ENTRY_TIMEOUT_EN
                idle_cnt <= 16'd0;
`endif
                if (event_code <= 4'd9) begin
                    if (digit_cnt == MAX_DIGITS) begin
                        entry_error <= 1'b1;
                    end else begin
                        shadow    <= shadow_next[13:0];
                        digit_cnt <= digit_cnt + 3'd1;
                    end
                end else if (event_code == CODE_CLEAR) begin
                    shadow    <= 14'd0;
                    digit_cnt <= 3'd0;
                end else if (event_code == CODE_ENTER) begin
                    if (digit_cnt == MAX_DIGITS) begin
                        password <= shadow;
                        touch    <= 1'b1;
                    end else begin
                        entry_error <= 1'b1;
                    end
                    shadow    <= 14'd0;
                    digit_cnt <= 3'd0;
                end else begin
                    entry_error <= 1'b1;
                end
            end
`ifdef ENTRY_TIMEOUT_EN
            else if (digit_cnt != 3'd0) begin
                if (idle_inc == TIMEOUT_TC) begin
                    shadow      <= 14'd0;
                    digit_cnt   <= 3'd0;
                    entry_error <= 1'b1;
                    idle_cnt    <= 16'd0;
                end else begin
                    idle_cnt <= idle_inc;
                end
            end
`endif
        end
    end

endmodule
